// File: rtl/map_pkg.sv
// Shared types and the object-priority encoder for the snake-map diff scanner.
package map_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        HEAD   = 3'd1,
        BODY   = 3'd2,
        APPLE  = 3'd3,
        BORDER = 3'd4
    } obj_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT_CMD,
        ST_FRAME_END
    } scan_state_t;

    // Border wins over everything so walls never get overdrawn by the snake.
    function automatic obj_code_t encode_obj(
        input logic i_head,
        input logic i_body,
        input logic i_apple,
        input logic i_border
    );
        if (i_border)     return BORDER;
        else if (i_head)  return HEAD;
        else if (i_body)  return BODY;
        else if (i_apple) return APPLE;
        else              return EMPTY;
    endfunction

endpackage

// File: rtl/map_code_ram.sv
// Previous-frame code store: asynchronous read, synchronous write, no reset.
module map_code_ram #(
    parameter int DEPTH  = 192,
    parameter int CODE_W = 3,
    localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [CODE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [CODE_W-1:0] o_rdata
);

    logic [CODE_W-1:0] r_mem [DEPTH];

    // NOTE: no reset on the array; the forced full redraw after reset fills it before any compare matters.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/map_diff_scanner.sv
// Raster scanner that issues draw requests only for cells whose code changed since last frame.
// Optional MAP_DIFF_STATS_EN adds an update_count output with the per-frame acknowledge count.
module map_diff_scanner
    import map_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int CODE_W = 3,
    localparam int X_W = $clog2(GRID_W),
    localparam int Y_W = $clog2(GRID_H)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              force_redraw,
    input  logic              snake_head,
    input  logic              snake_body,
    input  logic              apple,
    input  logic              border,
    input  logic              cmd_done,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [CODE_W-1:0] obj_code,
    output logic              en_update,
    output logic              busy,
    output logic              init_cycle,
    output logic              frame_done
`ifdef MAP_DIFF_STATS_EN
    ,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] update_count
`endif
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
`ifdef MAP_DIFF_STATS_EN
    localparam int CNT_W = $clog2(CELLS + 1);
`endif

    scan_state_t       r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [CODE_W-1:0] r_obj_code;
    logic              r_en_update;
    logic              r_init_cycle;
    logic              r_redraw_pending;
    logic              r_frame_done;
`ifdef MAP_DIFF_STATS_EN
    logic [CNT_W-1:0]  r_ack_cnt;
    logic [CNT_W-1:0]  r_update_count;
`endif

    obj_code_t         w_code_enum;
    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] w_prev_code;
    logic [IDX_W-1:0]  w_idx;
    logic              w_changed;
    logic              w_x_last;
    logic              w_last_cell;
    logic [X_W-1:0]    w_x_next;
    logic [Y_W-1:0]    w_y_next;
    logic              w_we;

    assign w_code_enum = encode_obj(snake_head, snake_body, apple, border);
    assign w_code      = CODE_W'(w_code_enum);
    assign w_idx       = IDX_W'(r_y) * IDX_W'(GRID_W) + IDX_W'(r_x);
    assign w_changed   = r_init_cycle || (w_code != w_prev_code);
    assign w_x_last    = (r_x == X_W'(GRID_W - 1));
    assign w_last_cell = w_x_last && (r_y == Y_W'(GRID_H - 1));
    assign w_x_next    = w_x_last ? '0 : r_x + X_W'(1);
    assign w_y_next    = w_x_last ? r_y + Y_W'(1) : r_y;
    assign w_we        = (r_state == ST_WAIT_CMD) && cmd_done;

    map_code_ram #(
        .DEPTH  (CELLS),
        .CODE_W (CODE_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (r_obj_code),
        .i_raddr (w_idx),
        .o_rdata (w_prev_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_x              <= '0;
            r_y              <= '0;
            r_obj_code       <= '0;
            r_en_update      <= 1'b0;
            r_init_cycle     <= 1'b1;
            r_redraw_pending <= 1'b0;
            r_frame_done     <= 1'b0;
`ifdef MAP_DIFF_STATS_EN
            r_ack_cnt        <= '0;
            r_update_count   <= '0;
`endif
        end else begin
            // NOTE: defaults first, later case branches override; all state uses non-blocking updates.
            r_frame_done     <= 1'b0;
            r_redraw_pending <= r_redraw_pending | force_redraw;
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_changed) begin
                        r_obj_code  <= w_code;
                        r_en_update <= 1'b1;
                        r_state     <= ST_WAIT_CMD;
                    end else if (w_last_cell) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_FRAME_END;
                    end else begin
                        r_x <= w_x_next;
                        r_y <= w_y_next;
                    end
                end
                ST_WAIT_CMD: begin
                    if (cmd_done) begin
                        r_en_update <= 1'b0;
`ifdef MAP_DIFF_STATS_EN
                        r_ack_cnt   <= r_ack_cnt + CNT_W'(1);
`endif
                        if (w_last_cell) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_FRAME_END;
                        end else begin
                            r_x     <= w_x_next;
                            r_y     <= w_y_next;
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_FRAME_END: begin
                    r_x              <= '0;
                    r_y              <= '0;
                    // A request arriving this very cycle applies to the frame now starting.
                    r_init_cycle     <= r_redraw_pending | force_redraw;
                    r_redraw_pending <= 1'b0;
`ifdef MAP_DIFF_STATS_EN
                    r_update_count   <= r_ack_cnt;
                    r_ack_cnt        <= '0;
`endif
                    r_state          <= enable ? ST_SCAN : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign obj_code   = r_obj_code;
    assign en_update  = r_en_update;
    assign busy       = (r_state != ST_IDLE);
    assign init_cycle = r_init_cycle;
    assign frame_done = r_frame_done;
`ifdef MAP_DIFF_STATS_EN
    assign update_count = r_update_count;
`endif

endmodule

// File: tb/tb_map_diff_scanner.sv
// Directed self-checking bench for map_diff_scanner on the default 16x12 grid.
module tb_map_diff_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       force_redraw;
    logic       snake_head, snake_body, apple, border;
    logic       cmd_done;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       en_update, busy, init_cycle, frame_done;
`ifdef MAP_DIFF_STATS_EN
    logic [7:0] update_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Map state driving the object lookup
    logic       head_en = 1'b0;
    logic       map_en  = 1'b0;
    logic       ov_en   = 1'b0;
    logic [3:0] hx = 4'd4;
    logic [3:0] hy = 4'd4;

    // Results of the last run_frame
    int q_x[$];
    int q_y[$];
    int q_c[$];
    int cycles;
    bit got_done;
    int first_init;
    int first_fd;
    int first_uc;
    int stable_err;

    always #5 clk = ~clk;

    map_diff_scanner #(.GRID_W(16), .GRID_H(12), .CODE_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .force_redraw (force_redraw),
        .snake_head   (snake_head),
        .snake_body   (snake_body),
        .apple        (apple),
        .border       (border),
        .cmd_done     (cmd_done),
        .x            (x),
        .y            (y),
        .obj_code     (obj_code),
        .en_update    (en_update),
        .busy         (busy),
        .init_cycle   (init_cycle),
        .frame_done   (frame_done)
`ifdef MAP_DIFF_STATS_EN
        ,
        .update_count (update_count)
`endif
    );

    always_comb begin
        border     = (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd11) ||
                     (ov_en && x == 4'd8 && y == 4'd6);
        snake_head = (head_en && x == hx && y == hy) || (ov_en && x == 4'd8 && y == 4'd6);
        snake_body = map_en && x == 4'd3 && y == 4'd4;
        apple      = map_en && x == 4'd10 && y == 4'd8;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input int i, input int ex, input int ey, input int ec);
        if (i < q_x.size())
            check(tag, q_x[i] * 10000 + q_y[i] * 100 + q_c[i], ex * 10000 + ey * 100 + ec);
        else
            check({tag, "_missing"}, q_x.size(), i + 1);
    endtask

    // Runs one frame from a negedge until the negedge where frame_done is seen.
    task automatic run_frame(input int hold, input bit stray, input int force_at);
        int  wait_cnt;
        bit  in_req;
        int  cx, cy, cc;
        q_x.delete(); q_y.delete(); q_c.delete();
        got_done   = 0;
        stable_err = 0;
        in_req     = 0;
        wait_cnt   = 0;
        cx = 0; cy = 0; cc = 0;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            cycles       = c;
            force_redraw = (c == force_at);
            if (c == 1) begin
                first_init = int'(init_cycle);
                first_fd   = int'(frame_done);
`ifdef MAP_DIFF_STATS_EN
                first_uc   = int'(update_count);
`endif
            end
            if (frame_done) begin
                got_done = 1;
                cmd_done = 1'b0;
                break;
            end
            if (en_update) begin
                if (!in_req) begin
                    cx = int'(x); cy = int'(y); cc = int'(obj_code);
                    q_x.push_back(cx); q_y.push_back(cy); q_c.push_back(cc);
                    in_req   = 1;
                    wait_cnt = 0;
                end else if (int'(x) != cx || int'(y) != cy || int'(obj_code) != cc) begin
                    stable_err++;
                end
                cmd_done = (wait_cnt >= hold);
                wait_cnt++;
            end else begin
                in_req   = 0;
                cmd_done = stray;
            end
        end
        if (!got_done) check("frame_timeout", 0, 1);
    endtask

    initial begin
        int bad;
        rst          = 1'b1;
        enable       = 1'b0;
        force_redraw = 1'b0;
        cmd_done     = 1'b0;
        first_uc     = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_init_cycle", int'(init_cycle), 1);
        check("rst_en_update", int'(en_update), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Frame 1: full redraw of a border-only map
        enable = 1'b1;
        run_frame(0, 1'b0, 0);
        check("f1_requests", q_x.size(), 192);
        check("f1_init", first_init, 1);
        bad = 0;
        for (int i = 0; i < q_x.size(); i++) begin
            if (q_x[i] != i % 16 || q_y[i] != i / 16 ||
                q_c[i] != (((i % 16) == 0 || (i % 16) == 15 || (i / 16) == 0 || (i / 16) == 11) ? 4 : 0))
                bad++;
        end
        check("f1_order_codes", bad, 0);

        // Frame 2: identical map, no requests, 193-cycle frame period
        run_frame(0, 1'b0, 0);
        check("f2_init_cleared", first_init, 0);
        check("f2_frame_done_pulse", first_fd, 0);
        check("f2_requests", q_x.size(), 0);
        check("f2_period", cycles, 193);

        // Frame 3: head, body, apple and a border+head overlap appear
        head_en = 1'b1; map_en = 1'b1; ov_en = 1'b1;
        hx = 4'd4; hy = 4'd4;
        run_frame(0, 1'b0, 0);
        check("f3_requests", q_x.size(), 4);
        check_req("f3_body", 0, 3, 4, 2);
        check_req("f3_head", 1, 4, 4, 1);
        check_req("f3_border_over_head", 2, 8, 6, 4);
        check_req("f3_apple", 3, 10, 8, 3);

        // Frame 4: head moves one cell right
        hx = 4'd5;
        run_frame(0, 1'b0, 0);
        check("f4_requests", q_x.size(), 2);
        check_req("f4_old_head", 0, 4, 4, 0);
        check_req("f4_new_head", 1, 5, 4, 1);

        // Frame 5: acknowledge held off 5 cycles, stray cmd_done while scanning
        hx = 4'd6;
        run_frame(5, 1'b1, 0);
`ifdef MAP_DIFF_STATS_EN
        check("f4_update_count", first_uc, 2);
`endif
        check("f5_requests", q_x.size(), 2);
        check_req("f5_old_head", 0, 5, 4, 0);
        check_req("f5_new_head", 1, 6, 4, 1);
        check("f5_hold_stable", stable_err, 0);

        // Frame 6: force_redraw mid-frame leaves this frame diff-only
        hx = 4'd7;
        run_frame(0, 1'b0, 50);
        check("f6_init", first_init, 0);
        check("f6_requests", q_x.size(), 2);
        check_req("f6_new_head", 1, 7, 4, 1);

        run_frame(0, 1'b0, 0);
        check("f7_init", first_init, 1);
        check("f7_requests", q_x.size(), 192);

        run_frame(0, 1'b0, 0);
        check("f8_init", first_init, 0);
        check("f8_requests", q_x.size(), 0);

        // force_redraw coinciding with FRAME_END applies to the next frame only
        force_redraw = 1'b1;
        run_frame(0, 1'b0, 0);
        check("f9_init", first_init, 1);
        check("f9_requests", q_x.size(), 192);

        run_frame(0, 1'b0, 0);
        check("f10_init", first_init, 0);
        check("f10_requests", q_x.size(), 0);

        // Asynchronous reset while a request is pending
        hx = 4'd8;
        cmd_done = 1'b0;
        bad = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (en_update) begin
                bad = 0;
                break;
            end
        end
        check("wait_req_seen", bad, 0);
        rst = 1'b1;
        #1;
        check("arst_en_update", int'(en_update), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_x", int'(x), 0);
        check("arst_obj_code", int'(obj_code), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_init_cycle", int'(init_cycle), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/map_diff_scanner.md
# map_diff_scanner

Parametrised raster scanner for the snake-game image generator. Walks every cell of a GRID_W×GRID_H map, encodes the object flags returned for the current cell, and compares the result against a stored copy of the previous frame. Issues a draw request to the display command block only for changed cells, or for every cell on a redraw frame, and holds each request until the command block acknowledges it.

## Interface
- GRID_W, 16, map width in cells (≥2)
- GRID_H, 12, map height in cells (≥2)
- CODE_W, 3, object code width (≥3)
- X_W / Y_W (localparam), $clog2(GRID_W) / $clog2(GRID_H)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run scanning
- force_redraw  in  1  request full redraw on next frame
- snake_head, snake_body, apple, border  in  1 each  object flags for the current (x,y), combinational from the lookup logic
- cmd_done  in  1  draw-command acknowledge
- x  out  X_W  current cell column
- y  out  Y_W  current cell row
- obj_code  out  CODE_W  code of the pending draw request
- en_update  out  1  draw request pending
- busy  out  1  scanner not idle (enable_loop)
- init_cycle  out  1  current/next frame is a full redraw
- frame_done  out  1  one-cycle pulse at frame end

## Operation
- Encoding priority: border 4 > head 1 > body 2 > apple 3 > empty 0; zero-extended to CODE_W.
- Raster order: x inner, y outer; cell index = y*GRID_W + x.
- FSM states:
  - IDLE: busy=0. Go to SCAN when enable=1.
  - SCAN: encode current cell. If init_cycle=1 or code≠mem[idx], latch obj_code, set en_update, go to WAIT_CMD. Otherwise advance one cell. After the last cell, go to FRAME_END.
  - WAIT_CMD: x, y, obj_code and en_update are held. On cmd_done=1, write obj_code to mem[idx], drop en_update, advance (or go to FRAME_END after the last cell).
  - FRAME_END: pulse frame_done; x,y←0; init_cycle←redraw_pending; clear redraw_pending. Go to SCAN if enable=1, otherwise IDLE.
- force_redraw sets redraw_pending in any state. The current frame is unaffected.
- enable is sampled only in IDLE and FRAME_END. Deasserting it mid-frame lets the current frame complete.
- cmd_done is ignored outside WAIT_CMD.
- Frame memory is not reset. The init_cycle=1 after reset guarantees it is fully written before any compare is used.

## Timing
- Reset values: x=0, y=0, obj_code=0, en_update=0, busy=0, frame_done=0, init_cycle=1, redraw_pending=0, state=IDLE.
- Unchanged cell costs 1 cycle.
- Changed cell costs 1 cycle plus the cmd_done wait. en_update rises the cycle after SCAN evaluates the cell and falls the cycle after cmd_done is sampled.
- Frame with no changes: GRID_W*GRID_H cycles in SCAN plus 1 cycle in FRAME_END.
- Wrap-around: x=GRID_W-1 → x=0, y+1. Cell (GRID_W-1, GRID_H-1) → FRAME_END.
- rst asserted mid-WAIT_CMD drops en_update immediately (asynchronous). The pending write is discarded.
- force_redraw and FRAME_END in the same cycle: that redraw request applies to the frame starting now. redraw_pending is not left set.

## Configuration
- MAP_DIFF_STATS_EN
  - Defined: adds output update_count, width $clog2(GRID_W*GRID_H+1). It counts the cmd_done acknowledges in the frame, is loaded at FRAME_END, and resets to 0.
  - Undefined: the port and counter are absent.

## Structure
- Package map_pkg:
  - obj_code_t enum: EMPTY=0, HEAD=1, BODY=2, APPLE=3, BORDER=4
  - scan_state_t enum
  - encode priority function
- Sub-module map_code_ram: GRID_W*GRID_H×CODE_W, one asynchronous read port, one synchronous write port, no reset.

## Test plan
- Reset: rst high for 3 cycles → x=0, y=0, init_cycle=1, en_update=0, busy=0, frame_done=0.
- First frame, border on edges only, cmd_done returned 1 cycle after each en_update → exactly 192 requests; frame_done pulses; init_cycle=0 afterwards.
- Second identical frame → zero en_update; frame_done exactly 193 cycles after the frame starts.
- Head moves from (4,4) to (5,4) → two requests in order: (4,4) with code 0, then (5,4) with code 1. Border+head asserted together on a cell → obj_code=4.
- cmd_done withheld for 5 cycles → x, y, obj_code and en_update stay stable; a stray cmd_done during SCAN has no effect.
- force_redraw mid-frame → remainder of that frame is diff-only; next frame issues 192 requests. With MAP_DIFF_STATS_EN, update_count equals 2 for the head-move frame.
